// File: rtl/j1708_rx_sm.sv
// j1708_rx_sm: receive-side J1708 message framer.
// Groups UART bytes into messages using the inter-byte idle gap and buffers
// each message internally. A message is checked for ownership, overflow,
// length, framing, checksum and FIFO space; good messages are flushed to the
// data FIFO and their length is written to the length FIFO. Messages that
// fail are dropped.
// Optional build macro: J1708_RX_STRIP_CHECKSUM_EN (checksum byte verified
// but not forwarded; the length excludes it).
// Ports:
//   clk, rst (async, active-high), enable (0 = synchronous clear)
//   rx_data/rx_valid/rx_frame_err : byte stream from UART RX
//   tx_message_process            : own transmitter is on the bus
//   data_fifo_free/length_fifo_full : FIFO space status
//   data_fifo_wr_data/data_fifo_wr, length_fifo_wr_data/length_fifo_wr : FIFO writes
//   rx_msg_done/rx_msg_error : one-cycle pulses; error_code : last error
//   rx_busy : high in RECEIVE, CHECK, FLUSH
module j1708_rx_sm #(
  parameter int unsigned CLK_FRQ_MHZ = 24,
  parameter int unsigned EOM_BITS    = 10,
  parameter int unsigned MAX_MSG_LEN = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  input  logic       tx_message_process,
  input  logic [7:0] data_fifo_free,
  input  logic       length_fifo_full,
  output logic [7:0] data_fifo_wr_data,
  output logic       data_fifo_wr,
  output logic [7:0] length_fifo_wr_data,
  output logic       length_fifo_wr,
  output logic       rx_msg_done,
  output logic       rx_msg_error,
  output logic [2:0] error_code,
  output logic       rx_busy
);

  localparam int unsigned BIT_PERIOD = 105 * CLK_FRQ_MHZ;
  localparam int unsigned GAP_MAX    = EOM_BITS * BIT_PERIOD;
  localparam int unsigned GAP_W      = $clog2(GAP_MAX + 1);
  localparam int unsigned CNT_W      = $clog2(MAX_MSG_LEN + 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_RECEIVE, S_CHECK, S_FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;
  logic [7:0]       msg_buf [MAX_MSG_LEN];
  logic [CNT_W-1:0] cnt, cnt_nxt, idx, idx_nxt, msg_len;
  logic [7:0]       sum, sum_nxt;
  logic             ovf, ovf_nxt, ferr, ferr_nxt, own, own_nxt;
  logic             pend, pend_nxt, pend_ferr, pend_ferr_nxt;
  logic [7:0]       pend_data, pend_data_nxt;
  logic             buf_we;
  logic [CNT_W-1:0] buf_wa;
  logic [7:0]       buf_wd;
  logic             err_hit;
  logic [2:0]       err_val;
  logic [7:0]       data_fifo_wr_data_nxt, length_fifo_wr_data_nxt;
  logic             data_fifo_wr_nxt, length_fifo_wr_nxt;
  logic             rx_msg_done_nxt, rx_msg_error_nxt, rx_busy_nxt;
  logic [2:0]       error_code_nxt;

  assign gap_done = (gap_cnt == GAP_W'(GAP_MAX));

  // Number of bytes forwarded to the data FIFO.
`ifdef J1708_RX_STRIP_CHECKSUM_EN
  assign msg_len = cnt - CNT_W'(1);
`else
  assign msg_len = cnt;
`endif

  // Idle-gap counter: cleared by every byte, saturates at the EOM gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      gap_cnt <= '0;
    else if (!enable || rx_valid) gap_cnt <= '0;
    else if (!gap_done)           gap_cnt <= gap_cnt + GAP_W'(1);
  end

  // Message buffer storage.
  always_ff @(posedge clk) begin
    if (buf_we) msg_buf[buf_wa] <= buf_wd;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_WAIT_IDLE;
      cnt                 <= '0;
      idx                 <= '0;
      sum                 <= '0;
      ovf                 <= 1'b0;
      ferr                <= 1'b0;
      own                 <= 1'b0;
      pend                <= 1'b0;
      pend_ferr           <= 1'b0;
      pend_data           <= '0;
      data_fifo_wr_data   <= '0;
      data_fifo_wr        <= 1'b0;
      length_fifo_wr_data <= '0;
      length_fifo_wr      <= 1'b0;
      rx_msg_done         <= 1'b0;
      rx_msg_error        <= 1'b0;
      error_code          <= '0;
      rx_busy             <= 1'b0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      idx                 <= idx_nxt;
      sum                 <= sum_nxt;
      ovf                 <= ovf_nxt;
      ferr                <= ferr_nxt;
      own                 <= own_nxt;
      pend                <= pend_nxt;
      pend_ferr           <= pend_ferr_nxt;
      pend_data           <= pend_data_nxt;
      data_fifo_wr_data   <= data_fifo_wr_data_nxt;
      data_fifo_wr        <= data_fifo_wr_nxt;
      length_fifo_wr_data <= length_fifo_wr_data_nxt;
      length_fifo_wr      <= length_fifo_wr_nxt;
      rx_msg_done         <= rx_msg_done_nxt;
      rx_msg_error        <= rx_msg_error_nxt;
      error_code          <= error_code_nxt;
      rx_busy             <= rx_busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt               = state;
    cnt_nxt                 = cnt;
    idx_nxt                 = idx;
    sum_nxt                 = sum;
    ovf_nxt                 = ovf;
    ferr_nxt                = ferr;
    own_nxt                 = own;
    pend_nxt                = pend;
    pend_ferr_nxt           = pend_ferr;
    pend_data_nxt           = pend_data;
    buf_we                  = 1'b0;
    buf_wa                  = '0;
    buf_wd                  = rx_data;
    err_hit                 = 1'b0;
    err_val                 = 3'd0;
    data_fifo_wr_data_nxt   = data_fifo_wr_data;
    data_fifo_wr_nxt        = 1'b0;
    length_fifo_wr_data_nxt = length_fifo_wr_data;
    length_fifo_wr_nxt      = 1'b0;
    rx_msg_done_nxt         = 1'b0;
    rx_msg_error_nxt        = 1'b0;
    error_code_nxt          = error_code;

    case (state)
      S_WAIT_IDLE: begin
        if (gap_done) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // A byte held over from CHECK/FLUSH starts the next message.
        if (pend || rx_valid) begin
          buf_we        = 1'b1;
          buf_wa        = '0;
          buf_wd        = pend ? pend_data : rx_data;
          cnt_nxt       = CNT_W'(1);
          sum_nxt       = buf_wd;
          ovf_nxt       = 1'b0;
          ferr_nxt      = pend ? pend_ferr : rx_frame_err;
          own_nxt       = tx_message_process;
          pend_nxt      = 1'b0;
          state_nxt     = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        if (tx_message_process) own_nxt = 1'b1;
        // A byte on the gap_done cycle wins: it extends the message.
        if (rx_valid) begin
          if (rx_frame_err) ferr_nxt = 1'b1;
          if (cnt < CNT_W'(MAX_MSG_LEN)) begin
            buf_we  = 1'b1;
            buf_wa  = cnt;
            buf_wd  = rx_data;
            cnt_nxt = cnt + CNT_W'(1);
            sum_nxt = sum + rx_data;
          end else begin
            ovf_nxt = 1'b1;
          end
        end else if (gap_done) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        if (own) begin
          err_hit = 1'b0;
        end else if (ovf) begin
          err_hit = 1'b1; err_val = 3'd1;
        end else if (cnt < CNT_W'(2)) begin
          err_hit = 1'b1; err_val = 3'd2;
        end else if (ferr) begin
          err_hit = 1'b1; err_val = 3'd4;
        end else if (sum != 8'h00) begin
          err_hit = 1'b1; err_val = 3'd3;
        end else if ((8'(msg_len) > data_fifo_free) || length_fifo_full) begin
          err_hit = 1'b1; err_val = 3'd5;
        end else begin
          state_nxt = S_FLUSH;
          idx_nxt   = '0;
        end
        if (err_hit) begin
          rx_msg_error_nxt = 1'b1;
          error_code_nxt   = err_val;
        end
      end
      S_FLUSH: begin
        if (idx < msg_len) begin
          data_fifo_wr_nxt      = 1'b1;
          data_fifo_wr_data_nxt = msg_buf[idx];
          idx_nxt               = idx + CNT_W'(1);
        end else begin
          length_fifo_wr_nxt      = 1'b1;
          length_fifo_wr_data_nxt = 8'(msg_len);
          rx_msg_done_nxt         = 1'b1;
          state_nxt               = S_IDLE;
        end
      end
      default: state_nxt = S_WAIT_IDLE;
    endcase

    // Bytes arriving while a message is being judged or flushed are held.
    if ((state == S_CHECK || state == S_FLUSH) && rx_valid) begin
      pend_nxt      = 1'b1;
      pend_data_nxt = rx_data;
      pend_ferr_nxt = rx_frame_err;
    end

    // Synchronous clear while disabled.
    if (!enable) begin
      state_nxt               = S_WAIT_IDLE;
      cnt_nxt                 = '0;
      idx_nxt                 = '0;
      sum_nxt                 = '0;
      ovf_nxt                 = 1'b0;
      ferr_nxt                = 1'b0;
      own_nxt                 = 1'b0;
      pend_nxt                = 1'b0;
      pend_ferr_nxt           = 1'b0;
      pend_data_nxt           = '0;
      buf_we                  = 1'b0;
      data_fifo_wr_data_nxt   = '0;
      data_fifo_wr_nxt        = 1'b0;
      length_fifo_wr_data_nxt = '0;
      length_fifo_wr_nxt      = 1'b0;
      rx_msg_done_nxt         = 1'b0;
      rx_msg_error_nxt        = 1'b0;
      error_code_nxt          = '0;
    end

    rx_busy_nxt = (state_nxt == S_RECEIVE) || (state_nxt == S_CHECK) ||
                  (state_nxt == S_FLUSH);
  end

endmodule

// File: doc/j1708_rx_sm.md
Name: j1708_rx_sm

Overview:
- Receive-side message framer for the J1708 port, between the UART RX byte block and the RX data and length FIFOs read by the MCU interface.
- Groups UART bytes into messages using the inter-byte idle gap and buffers each message internally.
- Validates length, framing, checksum and ownership, then flushes a good message to the data FIFO and writes its length to the length FIFO.
- Messages that fail validation are dropped and never appear in the FIFOs.

Parameters:
- CLK_FRQ_MHZ, 24, clock frequency in MHz. BIT_PERIOD = 105*CLK_FRQ_MHZ cycles.
- EOM_BITS, 10, idle bit times that terminate a message.
- MAX_MSG_LEN, 21, maximum bytes per message, MID and checksum included.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  0 = synchronous clear to the reset state
- rx_data  in  8  byte from UART RX
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_frame_err  in  1  qualifies rx_valid; stop-bit error on this byte
- tx_message_process  in  1  own transmitter is driving the bus
- data_fifo_free  in  8  free entries in the data FIFO
- length_fifo_full  in  1  length FIFO full
- data_fifo_wr_data  out  8  byte to the data FIFO
- data_fifo_wr  out  1  data FIFO write strobe
- length_fifo_wr_data  out  8  message length in bytes
- length_fifo_wr  out  1  length FIFO write strobe
- rx_msg_done  out  1  pulse, message delivered
- rx_msg_error  out  1  pulse, message dropped on error
- error_code  out  3  last error, held until next error
- rx_busy  out  1  high in RECEIVE, CHECK, FLUSH

Behaviour:
- Reset or !enable: all outputs 0, buffer count 0, gap counter 0, state WAIT_IDLE.
- Gap counter:
  - Cleared on every rx_valid; otherwise increments and saturates at EOM_BITS*BIT_PERIOD.
  - gap_done = counter at saturation.
- States:
  - WAIT_IDLE: gap_done -> IDLE. Bytes arriving here are discarded, so reception never starts mid-message.
  - IDLE: rx_valid -> store byte at buf[0], cnt=1, sum=byte, flags cleared, -> RECEIVE.
  - RECEIVE:
    - rx_valid with cnt<MAX_MSG_LEN: store at buf[cnt], cnt+1, sum+=byte (8-bit wrap).
    - rx_valid with cnt==MAX_MSG_LEN: set ovf; byte discarded; cnt holds.
    - rx_frame_err on any byte sets ferr.
    - tx_message_process high in any cycle sets own.
    - gap_done -> CHECK.
  - CHECK (1 cycle): first match wins.
    - own -> drop silently: no pulse, error_code unchanged.
    - ovf -> code 1.
    - cnt<2 -> code 2.
    - ferr -> code 4.
    - sum!=0 -> code 3.
    - data_fifo_free<cnt or length_fifo_full -> code 5.
    - Error case: rx_msg_error pulses 1 cycle, error_code registered, -> IDLE.
    - No drop -> FLUSH, index=0.
  - FLUSH:
    - One byte per cycle: data_fifo_wr=1, data_fifo_wr_data=buf[index].
    - After byte cnt-1, next cycle: length_fifo_wr=1, length_fifo_wr_data=cnt, rx_msg_done=1, -> IDLE.
    - Latency from entering CHECK to the length write is cnt+1 cycles.
- Byte arriving in CHECK/FLUSH: latched in a one-byte holding register (pend flag set). On the IDLE entry cycle it is consumed as buf[0], exactly as an IDLE rx_valid.
- Simultaneous rx_valid and gap_done in RECEIVE: the byte is appended and the gap resets; no CHECK entry.
- enable deasserted mid-FLUSH: writes stop immediately. The partially written message is the responsibility of the FIFO owner, which clears its FIFOs on !enable.
- All outputs are registered.

Optional Feature:
- Macro J1708_RX_STRIP_CHECKSUM_EN.
- Defined:
  - The checksum byte is verified but not written to the data FIFO.
  - length_fifo_wr_data = cnt-1.
  - FIFO space check uses cnt-1.
- Undefined: checksum byte is forwarded and the length includes it.

Test Plan:
- CLK_FRQ_MHZ=1. Bytes 0x80,0x54,0x10,0x1C spaced 1 bit time, then 10-bit idle -> 4 data_fifo_wr with those bytes in order, length_fifo_wr_data=4, one rx_msg_done. With macro defined: 3 bytes and length 3.
- Same message with last byte 0x1D -> no FIFO writes, rx_msg_error pulse, error_code=3.
- 23 bytes back-to-back -> error_code=1, no writes. Next valid 4-byte message is delivered normally.
- Message 0x80,0x54,0x10,0x1C with tx_message_process high during byte 0 -> no writes, no pulses, error_code unchanged.
- data_fifo_free=3 with the 4-byte good message -> error_code=5. Separately, byte 0x80 with rx_frame_err -> error_code=4.
- Byte 0x80 arriving while in FLUSH -> current message fully written, then a new message starts with buf[0]=0x80. Byte arriving after reset before a 10-bit idle -> ignored.
